// File: rtl/dcm_ps_arb_pkg.sv
// Shared definitions for the DCM phase-shift arbiter: state encoding, ack status codes,
// default limits and the offset limit check.
package dcm_ps_arb_pkg;

    localparam int OFS_W       = 10;
    localparam int MAX_OFS_DEF = 255;
    localparam int TIMEOUT_DEF = 1023;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic [1:0] ACK_OK      = 2'b00;
    localparam logic [1:0] ACK_LIMIT   = 2'b01;
    localparam logic [1:0] ACK_TIMEOUT = 2'b10;
    localparam logic [1:0] ACK_UNLOCK  = 2'b11;

    // True when one more step in the given direction would leave [-maxOfs, +maxOfs].
    function automatic logic stepExceeds(input logic signed [OFS_W-1:0] ofs,
                                         input logic inc, input int maxOfs);
        int nextOfs;
        nextOfs = int'(ofs) + (inc ? 1 : -1);
        return (nextOfs > maxOfs) || (nextOfs < -maxOfs);
    endfunction

endpackage

// File: rtl/dcm_ps_arb_if.sv
// Requester, status and DCM phase-shift signals of the arbiter.
// master: the arbiter side; slave: requesters plus the DCM.
interface dcm_ps_arb_if;
    import dcm_ps_arb_pkg::*;

    logic                    dcmlocked;
    logic                    req0_valid;
    logic                    req0_inc;
    logic                    req1_valid;
    logic                    req1_inc;
    logic                    req0_ack;
    logic                    req1_ack;
    logic [1:0]              ack_status;
    logic                    ps_en;
    logic                    ps_inc;
    logic                    ps_done;
    logic signed [OFS_W-1:0] phase_ofs;
    logic                    busy;
    logic                    timeout_err;

    modport master (
        input  dcmlocked, req0_valid, req0_inc, req1_valid, req1_inc, ps_done,
        output req0_ack, req1_ack, ack_status, ps_en, ps_inc, phase_ofs, busy, timeout_err
    );

    modport slave (
        output dcmlocked, req0_valid, req0_inc, req1_valid, req1_inc, ps_done,
        input  req0_ack, req1_ack, ack_status, ps_en, ps_inc, phase_ofs, busy, timeout_err
    );

endinterface

// File: rtl/dcm_ps_arb_rr.sv
// Two-way round-robin grant; pointer favours requester 0 after reset.
// Latency: combinational grant, pointer moves on the edge a grant is taken.
// Backpressure: grant is only consumed when take is high; otherwise pointer holds.
module ps_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gntVld,
    output logic gntIdx
);

    logic ptr;

    always_comb begin
        gntVld = req0 | req1;
        gntIdx = 1'b0;
        if (req0 && req1)
            gntIdx = ptr;
        else
            gntIdx = req1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (take && gntVld)
            ptr <= ~gntIdx;
    end

endmodule

// File: rtl/dcm_ps_arb.sv
// Arbitrates two phase-step requesters onto one DCM phase-shift port, tracking the net offset.
// Latency: request to ps_en 2 cycles; ack one cycle after ps_done, timeout, unlock or limit reject.
// Backpressure: requesters hold valid until their ack; no grant while busy or while the DCM is unlocked.
module dcm_ps_arb
    import dcm_ps_arb_pkg::*;
#(
    parameter int MAX_OFS = MAX_OFS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dcm_ps_arb_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic signed [OFS_W-1:0] ONE = 1;

    logic [1:0]              state;
    logic                    grantIdx;
    logic                    grantDir;
    logic [CNT_W-1:0]        tmoCnt;
    logic                    psEn;
    logic                    psInc;
    logic                    ack0;
    logic                    ack1;
    logic [1:0]              ackStatus;
    logic signed [OFS_W-1:0] phaseOfs;
    logic                    tmoErr;

    logic gntVld;
    logic gntIdx;
    logic take;
    logic reqDir;

    assign take   = (state == ST_IDLE) && bus.dcmlocked;
    assign reqDir = gntIdx ? bus.req1_inc : bus.req0_inc;

    ps_rr_arb u_rr (
        .clk    (clk),
        .reset  (reset),
        .req0   (bus.req0_valid),
        .req1   (bus.req1_valid),
        .take   (take),
        .gntVld (gntVld),
        .gntIdx (gntIdx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grantIdx  <= 1'b0;
            grantDir  <= 1'b0;
            tmoCnt    <= '0;
            psEn      <= 1'b0;
            psInc     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            ackStatus <= ACK_OK;
            phaseOfs  <= '0;
            tmoErr    <= 1'b0;
        end else begin
            psEn <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take && gntVld) begin
                        grantIdx <= gntIdx;
                        grantDir <= reqDir;
                        if (stepExceeds(phaseOfs, reqDir, MAX_OFS)) begin
                            ack0      <= ~gntIdx;
                            ack1      <= gntIdx;
                            ackStatus <= ACK_LIMIT;
                            state     <= ST_ACK;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!bus.dcmlocked) begin
                        ack0      <= ~grantIdx;
                        ack1      <= grantIdx;
                        ackStatus <= ACK_UNLOCK;
                        state     <= ST_ACK;
                    end else begin
                        psEn   <= 1'b1;
                        psInc  <= grantDir;
                        tmoCnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.dcmlocked) begin
                        ack0      <= ~grantIdx;
                        ack1      <= grantIdx;
                        ackStatus <= ACK_UNLOCK;
                        state     <= ST_ACK;
                    end else if (bus.ps_done) begin
                        phaseOfs  <= grantDir ? phaseOfs + ONE : phaseOfs - ONE;
                        ack0      <= ~grantIdx;
                        ack1      <= grantIdx;
                        ackStatus <= ACK_OK;
                        state     <= ST_ACK;
                    end else if (tmoCnt == CNT_W'(TIMEOUT - 1)) begin
                        tmoErr    <= 1'b1;
                        ack0      <= ~grantIdx;
                        ack1      <= grantIdx;
                        ackStatus <= ACK_TIMEOUT;
                        state     <= ST_ACK;
                    end else begin
                        tmoCnt <= tmoCnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Losing lock invalidates any accumulated offset, whatever the state.
            if (!bus.dcmlocked)
                phaseOfs <= '0;
        end
    end

    assign bus.ps_en       = psEn;
    assign bus.ps_inc      = psInc;
    assign bus.req0_ack    = ack0;
    assign bus.req1_ack    = ack1;
    assign bus.ack_status  = ackStatus;
    assign bus.phase_ofs   = phaseOfs;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.timeout_err = tmoErr;

endmodule

// File: doc/dcm_ps_arb.md
DCM_PS_ARB -- requirements
Module: dcm_ps_arb

Interface
REQ-001 Parameter MAX_OFS, default 255, magnitude limit of the signed net phase offset in DCM steps.
REQ-002 Parameter TIMEOUT, default 1023, maximum cycles to wait for ps_done after ps_en.
REQ-003 clk  in  1  clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dcmlocked  in  1  DCM lock status.
REQ-006 req0_valid, req0_inc  in  1,1  requester 0 (calibration controller) step request and direction (1 = increment).
REQ-007 req1_valid, req1_inc  in  1,1  requester 1 (host/manual trim) step request and direction.
REQ-008 req0_ack, req1_ack  out  1,1  one-cycle completion pulse per requester.
REQ-009 ack_status  out  2  status valid with any ack: 00 ok, 01 limit reject, 10 timeout, 11 unlock abort.
REQ-010 ps_en, ps_inc  out  1,1  DCM phase-shift enable and direction, registered.
REQ-011 ps_done  in  1  DCM phase-shift completion.
REQ-012 phase_ofs  out  10  signed two's-complement net offset (increments minus decrements).
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 timeout_err  out  1  sticky, set on any timeout, cleared only by reset.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-016 In IDLE with dcmlocked=1 and at least one valid, the arbiter SHALL grant one requester, latch its direction, and enter ISSUE next cycle.
REQ-017 With both valid, the grant SHALL alternate round-robin, starting with requester 0 after reset.
REQ-018 If the granted step would make |phase_ofs| exceed MAX_OFS, the FSM SHALL skip ISSUE/WAIT, go to ACK with status 01, and leave ps_en low.
REQ-019 In ISSUE, ps_en SHALL be 1 for exactly one cycle with ps_inc equal to the latched direction; then WAIT.
REQ-020 In WAIT, ps_done=1 SHALL move to ACK with status 00 and update phase_ofs by +1/-1 on the same edge.
REQ-021 In WAIT, a cycle counter reaching TIMEOUT SHALL move to ACK with status 10, set timeout_err, and leave phase_ofs unchanged.
REQ-022 In ACK, exactly the granted reqN_ack SHALL pulse one cycle, then IDLE; the same request SHALL NOT be regranted in that ACK cycle.
REQ-023 Requesters SHALL hold valid and direction until ack; withdrawal before grant is legal, and changes after grant SHALL be ignored.
REQ-024 ps_done outside WAIT SHALL be ignored.
REQ-025 dcmlocked=0 in ISSUE or WAIT SHALL go to ACK with status 11; in any state it SHALL clear phase_ofs to 0 and hold ps_en low.
REQ-026 While dcmlocked=0, no grant SHALL occur.
REQ-027 Minimum request-to-ps_en latency SHALL be 2 cycles (grant edge, ISSUE edge).

Reset
REQ-028 On reset: state IDLE, ps_en=0, ps_inc=0, req0_ack=0, req1_ack=0, ack_status=00, phase_ofs=0, busy=0, timeout_err=0, round-robin pointer at requester 0, timeout counter 0.
REQ-029 Reset mid-operation SHALL abort without any ack; reset dominates all other inputs.

Structure
REQ-030 A shared package SHALL hold the state encoding, ack_status codes, and MAX_OFS/TIMEOUT defaults.
REQ-031 One sub-module, ps_rr_arb (two-way round-robin grant with pointer), SHALL be instantiated; the remainder stays flat.

Verification
REQ-032 req0 inc, ps_done 5 cycles after ps_en -> ps_en one cycle, req0_ack with 00, phase_ofs=+1.
REQ-033 req0 and req1 valid together for 4 requests (req1 dec) -> grants 0,1,0,1, phase_ofs=0.
REQ-034 phase_ofs=+255, req1 inc -> no ps_en, req1_ack with 01, phase_ofs stays 255.
REQ-035 ps_done never asserted -> ack at 1023 cycles in WAIT with 10, timeout_err=1 until reset.
REQ-036 dcmlocked drops in WAIT at phase_ofs=-3 -> ack with 11, phase_ofs=0, no grants until relock.
REQ-037 reset asserted in WAIT -> next cycle all outputs at reset values, no ack pulse.
